// File: rtl/dist_pkg.sv
// dist_pkg: shared definitions for the packet distribution / routing blocks.
//   dist_state_t : distributor FSM state encoding (IDLE, BUSY, DROP)
//   onehot_ok()  : true when exactly one bit of a (zero-extended) mask is set
package dist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } dist_state_t;

  // Widest destination mask the helper accepts; callers zero-extend.
  localparam int ONEHOT_MAX_W = 32;

  function automatic logic onehot_ok(input logic [ONEHOT_MAX_W-1:0] v);
    // v & (v-1) clears the lowest set bit; result is zero only for 0 or 1 bits set.
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/dist_slot.sv
// dist_slot: one-entry valid/ready output register with a one-hot valid.
//   clk, rst            : clock, async active-high reset
//   load                : capture load_* this cycle (overrides a same-cycle drain)
//   load_vld/data/tail  : one-hot port valid, payload, tail flag to capture
//   out_rdy             : per-port ready from the consumers
//   out_vld/data/tail   : registered slot contents
//   drain               : the held flit transfers this cycle
module dist_slot
  import dist_pkg::*;
#(
  parameter int wd = 4,
  parameter int dw = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [wd-1:0] load_vld,
  input  logic [dw-1:0] load_data,
  input  logic          load_tail,
  input  logic [wd-1:0] out_rdy,
  output logic [wd-1:0] out_vld,
  output logic [dw-1:0] out_data,
  output logic          out_tail,
  output logic          drain
);

  // Only the ready of the port currently being driven matters.
  assign drain = |(out_vld & out_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= '0;
      out_data <= '0;
      out_tail <= 1'b0;
    end else if (load) begin
      out_vld  <= load_vld;
      out_data <= load_data;
      out_tail <= load_tail;
    end else if (drain) begin
      // Payload is left in place; only the valid is retired.
      out_vld  <= '0;
    end
  end

endmodule

// File: rtl/pkt_dist.sv
// pkt_dist: 1-to-wd packet distributor. Steers each packet to the one-hot
// port named in its head flit and holds that route until the tail.
//   clk, rst                      : clock, async active-high reset
//   in_vld/head/tail/dest/data    : input flit stream
//   in_rdy                        : input ready (combinational)
//   out_vld/data/tail, out_rdy    : registered per-port output, shared payload
//   err                           : one-cycle pulse on a stray body flit or bad head
//   pkt_cnt                       : wrapping count of tail flits delivered
module pkt_dist
  import dist_pkg::*;
#(
  parameter int wd = 4,
  parameter int dw = 32,
  parameter int cw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic          in_head,
  input  logic          in_tail,
  input  logic [wd-1:0] in_dest,
  input  logic [dw-1:0] in_data,
  output logic          in_rdy,
  output logic [wd-1:0] out_vld,
  output logic [dw-1:0] out_data,
  output logic          out_tail,
  input  logic [wd-1:0] out_rdy,
  output logic          err,
  output logic [cw-1:0] pkt_cnt
);

  dist_state_t   state, state_nxt;
  logic [wd-1:0] route, route_nxt;
  logic          err_nxt;
  logic          load;
  logic [wd-1:0] load_vld;
  logic          drain;
  logic          bad_head;
  logic          xfer;

  assign bad_head = in_head & ~onehot_ok(ONEHOT_MAX_W'(in_dest));

  // Bad heads and dropped flits never touch the slot, so they are taken
  // even while the slot is stalled.
  assign in_rdy = ~|out_vld | drain | (state == DROP) |
                  ((state == IDLE) & in_vld & bad_head);
  assign xfer   = in_vld & in_rdy;

  dist_slot #(.wd(wd), .dw(dw)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_vld  (load_vld),
    .load_data (in_data),
    .load_tail (in_tail),
    .out_rdy   (out_rdy),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_tail  (out_tail),
    .drain     (drain)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      route <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      route <= route_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    route_nxt = route;
    err_nxt   = 1'b0;
    load      = 1'b0;
    load_vld  = '0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (!in_head) begin
            err_nxt = 1'b1;
          end else if (bad_head) begin
            err_nxt = 1'b1;
            if (!in_tail) state_nxt = DROP;
          end else begin
            load      = 1'b1;
            load_vld  = in_dest;
            route_nxt = in_dest;
            if (!in_tail) state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          load     = 1'b1;
          load_vld = route;
          if (in_tail) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (xfer && in_tail) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pkt_cnt <= '0;
    else if (drain && out_tail) pkt_cnt <= pkt_cnt + cw'(1);
  end

endmodule

// File: tb/tb_pkt_dist.sv
module tb_pkt_dist;
  import dist_pkg::*;

  localparam int wd = 4;
  localparam int dw = 32;
  localparam int cw = 8;

  typedef struct {
    logic [wd-1:0] port;
    logic [dw-1:0] data;
    logic          tail;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld, in_head, in_tail;
  logic [wd-1:0] in_dest;
  logic [dw-1:0] in_data;
  logic          in_rdy;
  logic [wd-1:0] out_vld;
  logic [dw-1:0] out_data;
  logic          out_tail;
  logic [wd-1:0] out_rdy;
  logic          err;
  logic [cw-1:0] pkt_cnt;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int deliveries = 0;
  logic [cw-1:0] exp_cnt = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pkt_dist #(.wd(wd), .dw(dw), .cw(cw)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_head(in_head), .in_tail(in_tail),
    .in_dest(in_dest), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_tail(out_tail),
    .out_rdy(out_rdy), .err(err), .pkt_cnt(pkt_cnt)
  );

  // Output monitor: every transfer pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_pulses++;
      if (|(out_vld & out_rdy)) begin
        exp_t e;
        deliveries++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit: out_vld=%b data=%h with nothing expected", out_vld, out_data);
        end else begin
          e = sb.pop_front();
          if (out_vld !== e.port || out_data !== e.data || out_tail !== e.tail) begin
            errors++;
            $display("FAIL delivery: got vld=%b data=%h tail=%b, expected vld=%b data=%h tail=%b",
                     out_vld, out_data, out_tail, e.port, e.data, e.tail);
          end
          if (e.tail) exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  // Drive one flit and wait for acceptance; exp_port=0 means it must be discarded.
  task automatic send(input logic head, input logic tail, input logic [wd-1:0] dest,
                      input logic [dw-1:0] data, input logic [wd-1:0] exp_port);
    logic r;
    int   n = 0;
    in_vld = 1'b1; in_head = head; in_tail = tail; in_dest = dest; in_data = data;
    forever begin
      @(negedge clk); r = in_rdy;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_rdy stayed 0 for data=%h", data);
        break;
      end
    end
    if (r && exp_port != '0) sb.push_back('{exp_port, data, tail});
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d flits still expected, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 0; in_head = 0; in_tail = 0; in_dest = '0; in_data = '0; out_rdy = 4'hF;
    idle(2);
    checks++;
    if (out_vld !== 4'b0 || out_data !== 32'h0 || out_tail !== 1'b0 || err !== 1'b0 ||
        pkt_cnt !== 8'd0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: vld=%b data=%h tail=%b err=%b cnt=%0d rdy=%b, required 0/0/0/0/0/1",
               out_vld, out_data, out_tail, err, pkt_cnt, in_rdy);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single();
    send(1, 1, 4'b0100, 32'hA5A5_0001, 4'b0100);
    @(negedge clk);
    checks++;
    if (out_vld !== 4'b0100 || out_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_latency: vld=%b data=%h, required 0100 a5a50001", out_vld, out_data);
    end
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL single_in_rdy: got %b, required 1", in_rdy);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (pkt_cnt !== 8'd1) begin
      errors++; $display("FAIL single_pkt_cnt: got %0d, required 1", pkt_cnt);
    end
    check_drained("single");
  endtask

  task automatic test_stall();
    send(1, 0, 4'b0001, 32'h1000_0000, 4'b0001);
    out_rdy = 4'hE;   // port 0 stalls; others ready but must be ignored
    in_vld = 1; in_head = 0; in_tail = 0; in_dest = 4'b1000; in_data = 32'h1000_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b0 || out_vld !== 4'b0001 || out_data !== 32'h1000_0000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: rdy=%b vld=%b data=%h, required 0 0001 10000000",
                 i, in_rdy, out_vld, out_data);
      end
      @(posedge clk); #1;
    end
    out_rdy = 4'hF;
    send(0, 0, 4'b1000, 32'h1000_0001, 4'b0001);
    send(1, 0, 4'b0010, 32'h1000_0002, 4'b0001);  // head bit ignored while BUSY
    send(0, 1, 4'b0100, 32'h1000_0003, 4'b0001);
    check_drained("stall");
  endtask

  task automatic test_back_to_back();
    send(1, 0, 4'b0010, 32'h2000_0000, 4'b0010);
    send(0, 1, 4'b0000, 32'h2000_0001, 4'b0010);
    in_vld = 1; in_head = 1; in_tail = 1; in_dest = 4'b1000; in_data = 32'h3000_0000;
    @(negedge clk);
    checks++;
    if (out_vld !== 4'b0010 || in_rdy !== 1'b1) begin
      errors++; $display("FAIL b2b_tail: vld=%b rdy=%b, required 0010 1", out_vld, in_rdy);
    end
    @(posedge clk); #1;
    sb.push_back('{4'b1000, 32'h3000_0000, 1'b1});
    in_vld = 0;
    @(negedge clk);
    checks++;
    if (out_vld !== 4'b1000) begin
      errors++; $display("FAIL b2b_head: vld=%b, required 1000", out_vld);
    end
    check_drained("b2b");
  endtask

  task automatic test_bad_head();
    int e0 = err_pulses;
    int d0 = deliveries;
    send(1, 0, 4'b0110, 32'h4000_0000, 4'b0);
    send(0, 0, 4'b0001, 32'h4000_0001, 4'b0);
    send(0, 1, 4'b0001, 32'h4000_0002, 4'b0);
    checks++;
    if (dut.state !== IDLE) begin
      errors++; $display("FAIL bad_head_state: got %0d, required IDLE", dut.state);
    end
    idle(3);
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++; $display("FAIL bad_head_err: %0d pulses, required 1", err_pulses - e0);
    end
    checks++;
    if (deliveries != d0) begin
      errors++; $display("FAIL bad_head_vld: %0d flits delivered, required 0", deliveries - d0);
    end
  endtask

  task automatic test_stray_body();
    int e0 = err_pulses;
    logic [cw-1:0] c0 = pkt_cnt;
    send(0, 1, 4'b0001, 32'h5000_0000, 4'b0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL stray_err_level: got %b, required 1", err);
    end
    idle(3);
    checks++;
    if (err_pulses - e0 != 1 || pkt_cnt !== c0) begin
      errors++;
      $display("FAIL stray_body: pulses=%0d cnt=%0d, required 1 %0d", err_pulses - e0, pkt_cnt, c0);
    end
  endtask

  task automatic test_wrap_and_reset();
    while (exp_cnt != 8'd255) begin
      send(1, 1, 4'b0001 << (exp_cnt % 4), {24'h600000, exp_cnt}, 4'b0001 << (exp_cnt % 4));
      idle(1);
    end
    idle(2);
    checks++;
    if (pkt_cnt !== 8'd255) begin
      errors++; $display("FAIL cnt_255: got %0d, required 255", pkt_cnt);
    end
    send(1, 1, 4'b0010, 32'h6000_0100, 4'b0010);
    idle(2);
    checks++;
    if (pkt_cnt !== 8'd0) begin
      errors++; $display("FAIL cnt_wrap: got %0d, required 0", pkt_cnt);
    end
    out_rdy = 4'h0;
    send(1, 0, 4'b0100, 32'h7000_0000, 4'b0100);
    in_vld = 1; in_head = 0; in_tail = 0; in_data = 32'h7000_0001;
    @(negedge clk);
    checks++;
    if (out_vld !== 4'b0100 || in_rdy !== 1'b0) begin
      errors++; $display("FAIL pre_reset_full: vld=%b rdy=%b, required 0100 0", out_vld, in_rdy);
    end
    #2 rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (out_vld !== 4'b0 || dut.state !== IDLE || in_rdy !== 1'b1 || pkt_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: vld=%b state=%0d rdy=%b cnt=%0d, required 0 IDLE 1 0",
               out_vld, dut.state, in_rdy, pkt_cnt);
    end
    in_vld = 0; out_rdy = 4'hF; exp_cnt = '0;
    idle(2);
    rst = 1'b0;
    idle(1);
    send(1, 1, 4'b1000, 32'h8000_0000, 4'b1000);
    check_drained("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_bad_head();
    test_stray_body();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
